// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states and the latched request record.
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dmem_req_t;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_ram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The array is deliberately not reset so contents survive a controller reset.
module dmem_ram_be #(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic          i_en,
   input  logic [3:0]    i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (i_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, accesses RAM, pulses a response.
//   state | meaning
//   IDLE  | ready for a request; stalls the core while a request is presented
//   WAIT  | wait states counting down; RAM access on the edge leaving WAIT
//   RESP  | one-cycle response pulse; core advances, no new accept
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 64,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [3:0]  req_be_i4,
   input  logic [31:0] req_addr_i32,
   input  logic [31:0] req_wdata_i32,
   output logic        req_ready_o,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o32,
   output logic        rsp_err_o,
   output logic        stall_o
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   dmem_state_e r_state, w_state_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   dmem_req_t   r_req, w_req_in, w_req_acc;
   logic        r_rsp_valid, r_rsp_err, r_rsp_load;
   logic        w_accept, w_access, w_err;
   logic [29:0] w_index;
   logic [31:0] w_ram_rdata;

   assign w_req_in    = '{we: req_we_i, be: req_be_i4, addr: req_addr_i32, wdata: req_wdata_i32};
   assign req_ready_o = reset_ni && (r_state == IDLE);
   assign w_accept    = req_valid_i && req_ready_o;

   // Zero-wait builds access RAM on the accept edge, straight from the request inputs.
   assign w_req_acc = (r_state == IDLE) ? w_req_in : r_req;
   assign w_index   = w_req_acc.addr[31:2] - BASE_ADDR[31:2];
   assign w_err     = (w_req_acc.addr[1:0] != 2'b00) || (w_index[29:AW] != '0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_access    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES == 0) begin
                  w_state_nxt = RESP;
                  w_access    = 1'b1;
               end else begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = RESP;
               w_access    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_req       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_load  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_rsp_valid <= w_access;
         r_rsp_err   <= w_access && w_err;
         r_rsp_load  <= w_access && !w_req_acc.we && !w_err;
         if (w_accept) r_req <= w_req_in;
      end
   end

   // Reset gates the enable so a store whose commit edge meets reset is dropped.
   dmem_ram_be #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
      .clk_i   (clk_i),
      .i_en    (w_access && reset_ni),
      .i_we    ((w_req_acc.we && !w_err) ? w_req_acc.be : 4'b0000),
      .i_addr  (w_index[AW-1:0]),
      .i_wdata (w_req_acc.wdata),
      .o_rdata (w_ram_rdata)
   );

   assign rsp_valid_o   = r_rsp_valid;
   assign rsp_err_o     = r_rsp_err;
   assign rsp_rdata_o32 = r_rsp_load ? w_ram_rdata : 32'h0;
   assign stall_o       = ((r_state == IDLE) && req_valid_i) || (r_state == WAIT);

endmodule
